// File: rtl/fa_bist_pkg.sv
// Shared types, sizes and the golden full-adder response for the full-adder BIST.
package fa_bist_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_CHECK  = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   localparam int NUM_VECTORS = 8;
   localparam int IDX_W       = 3;
   localparam int ERR_W       = 4;
   localparam int CNT_W       = 4;

   // Returns {exp_sum, exp_cout} for idx = {a, b, cin}.
   function automatic logic [1:0] golden(input logic [IDX_W-1:0] idx);
      logic s;
      logic c;
      s = ^idx;
      c = (idx[2] & idx[1]) | (idx[2] & idx[0]) | (idx[1] & idx[0]);
      return {s, c};
   endfunction

endpackage

// File: rtl/fa_golden.sv
// Combinational reference response of a correct full adder for one test vector.
module fa_golden
   import fa_bist_pkg::*;
(
   input  logic [IDX_W-1:0] idx,
   output logic             exp_sum,
   output logic             exp_cout
);

   assign {exp_sum, exp_cout} = golden(idx);

endmodule

// File: rtl/full_adder_bist.sv
// Walks a full adder through all 8 input vectors, waits SETTLE_CYCLES per vector,
// checks the response and reports pass, error count and per-vector failure mask.
module full_adder_bist
   import fa_bist_pkg::*;
#(
   parameter int SETTLE_CYCLES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic             a,
   output logic             b,
   output logic             cin,
   input  logic             sum,
   input  logic             cout,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [ERR_W-1:0] err_count,
   output logic [7:0]       fail_mask
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_VECTORS - 1);

   // Valid/ready does not apply here: start is a level request sampled only in
   // IDLE, and done is a single-cycle pulse with results held until the next start.

   state_t             state;
   state_t             state_next;
   logic [IDX_W-1:0]   idx;
   logic [IDX_W-1:0]   idx_next;
   logic [CNT_W-1:0]   cnt;
   logic [CNT_W-1:0]   cnt_next;
   logic [ERR_W-1:0]   err_next;
   logic [7:0]         mask_next;
   logic               pass_next;
   logic               done_next;
   logic               busy_next;
   logic               exp_sum;
   logic               exp_cout;
   logic               mismatch;

   fa_golden u_golden (
      .idx      (idx),
      .exp_sum  (exp_sum),
      .exp_cout (exp_cout)
   );

   // The vector index register is the drive register, so the pins are registered.
   assign a   = idx[2];
   assign b   = idx[1];
   assign cin = idx[0];

   // One mismatch per vector regardless of how many response bits are wrong.
   assign mismatch = (sum != exp_sum) || (cout != exp_cout);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         idx       <= '0;
         cnt       <= '0;
         err_count <= '0;
         fail_mask <= 8'h00;
         pass      <= 1'b0;
         done      <= 1'b0;
         busy      <= 1'b0;
      end else begin
         state     <= state_next;
         idx       <= idx_next;
         cnt       <= cnt_next;
         err_count <= err_next;
         fail_mask <= mask_next;
         pass      <= pass_next;
         done      <= done_next;
         busy      <= busy_next;
      end
   end

   always_comb begin
      state_next = state;
      idx_next   = idx;
      cnt_next   = cnt;
      err_next   = err_count;
      mask_next  = fail_mask;
      pass_next  = pass;
      done_next  = 1'b0;
      busy_next  = busy;

      case (state)
         ST_IDLE: begin
            if (start) begin
               state_next = ST_SETTLE;
               idx_next   = '0;
               cnt_next   = '0;
               err_next   = '0;
               mask_next  = 8'h00;
               pass_next  = 1'b0;
               busy_next  = 1'b1;
            end
         end

         ST_SETTLE: begin
            if (cnt == CNT_LAST) begin
               state_next = ST_CHECK;
            end else begin
               cnt_next = cnt + 1'b1;
            end
         end

         ST_CHECK: begin
            if (mismatch) begin
               mask_next[idx] = 1'b1;
               err_next       = err_count + 1'b1;
            end
            if (idx == IDX_LAST) begin
               // Verdict uses this cycle's updated count so vector 7 is included.
               state_next = ST_DONE;
               done_next  = 1'b1;
               pass_next  = (err_next == '0);
            end else begin
               state_next = ST_SETTLE;
               idx_next   = idx + 1'b1;
               cnt_next   = '0;
            end
         end

         ST_DONE: begin
            state_next = ST_IDLE;
            busy_next  = 1'b0;
         end

         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

endmodule

// File: doc/full_adder_bist.md
# full_adder_bist

Built-in self-test controller for the single-bit full adder. It drives the adder's `a`/`b`/`cin` inputs through all 8 input combinations. It samples `sum`/`cout` after a programmable settle time and compares them against a golden model. It reports pass/fail, an error count and a per-vector failure mask. This is the synthesizable response-checking end of the full-adder stimulus interface, so adder instances can be checked on hardware without a simulator bench.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 2: cycles each vector is held before sampling; legal range 1..15.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  run request, sampled in IDLE only.
- `a`  out  1  adder operand A (registered).
- `b`  out  1  adder operand B (registered).
- `cin`  out  1  adder carry-in (registered).
- `sum`  in  1  adder sum response.
- `cout`  in  1  adder carry-out response.
- `busy`  out  1  high from the first SETTLE cycle through DONE.
- `done`  out  1  one-cycle pulse at end of run.
- `pass`  out  1  high when the last run had zero mismatches; held until next start.
- `err_count`  out  4  mismatching vectors in the last run, 0..8.
- `fail_mask`  out  8  bit i set if vector i mismatched.

## Operation
- Vector index `idx` is 3 bits. Drive mapping: `a = idx[2]`, `b = idx[1]`, `cin = idx[0]`. Order is 0 through 7 (000, 001, …, 111).
- Expected response: `exp_sum = ^idx`; `exp_cout = majority(idx[2], idx[1], idx[0])`.
- FSM states: IDLE, SETTLE, CHECK, DONE.
  - IDLE: if `start` is high, go to SETTLE. On that transition, set `idx = 0`, drive vector 0, and clear `err_count`, `fail_mask`, `pass` and the settle counter.
  - SETTLE: the settle counter increments each cycle. When it reaches `SETTLE_CYCLES - 1`, go to CHECK.
  - CHECK: compare `{sum, cout}` against the expected response. On mismatch, set `fail_mask[idx]` and increment `err_count`. A vector counts once even if both bits are wrong.
    - If `idx == 7`, go to DONE.
    - Otherwise increment `idx`, drive the next vector, reset the settle counter and go to SETTLE.
  - DONE: `done = 1` and `pass = (err_count == 0)`, both registered on entry. Go to IDLE on the next cycle.
- `start` is ignored outside IDLE, and holding it high does not extend a run. If `start` is still high in the cycle after DONE, a new run begins.
- `a`/`b`/`cin` hold vector 7 after a run until the next start or reset.
- `err_count` cannot overflow: maximum 8 fits in 4 bits.

## Timing
- Reset values: state IDLE, `a = b = cin = 0`, `busy = 0`, `done = 0`, `pass = 0`, `err_count = 0`, `fail_mask = 8'h00`.
- Edge E0 is the edge that samples `start`. Vector 0 is visible on the pins in the cycle after E0.
- Each vector occupies `SETTLE_CYCLES + 1` cycles. The response is sampled at the end of the single CHECK cycle.
- DONE is entered `8*(SETTLE_CYCLES+1)` edges after E0, and `done` is high for the one cycle following that edge.
  - Default `SETTLE_CYCLES = 2`: DONE is entered 24 edges after E0, with `done` high in the following cycle.
- Results (`pass`, `err_count`, `fail_mask`) are final and stable from the `done` cycle until the next start.
- Reset mid-run: an immediate asynchronous return to all reset values. Partial results are discarded and no `done` pulse occurs.

## Structure
- Package `fa_bist_pkg` contains:
  - state enum;
  - `NUM_VECTORS = 8`;
  - `IDX_W = 3`;
  - `ERR_W = 4`;
  - a golden-model function returning `{exp_sum, exp_cout}` for a 3-bit index.
- Sub-module `fa_golden` is the combinational reference model, `idx[2:0]` to `{exp_sum, exp_cout}`. It is instantiated once and shared with the bench scoreboard.
- The FSM, counters and result registers all live in `full_adder_bist`.

## Test plan
- Correct adder attached, `SETTLE_CYCLES = 2`, `start` pulsed for one cycle: `done` pulses 25 cycles after the start-sampling edge, with `pass = 1`, `err_count = 0` and `fail_mask = 8'h00`.
- Adder with `cout` stuck at 0: `pass = 0`, `err_count = 4`, `fail_mask = 8'hE8` (vectors 3, 5, 6, 7).
- Adder with `sum` inverted and `cout` inverted: `err_count = 8`, `fail_mask = 8'hFF`; each vector is counted once.
- `start` held high continuously: back-to-back runs, with exactly one `done` pulse per run. A second `start` pulse mid-run has no effect on cycle count or results.
- Assert `rst` during the CHECK of vector 4 in a failing run: outputs return to reset values on the same edge and no `done` pulse follows. The next start yields fresh results, with nothing carried over from the aborted run.
- `SETTLE_CYCLES = 1` and `SETTLE_CYCLES = 15`: verify the per-vector period is 2 and 16 cycles, and that the drive sequence on `a`/`b`/`cin` is 000 through 111.
